// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: state, opcode and control-field encodings for the multi-cycle MIPS controller.
package multicycle_control_pkg;
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10
`ifdef MC_ADDI_EN
    , S_ADDI_EX = 4'd11,
    S_ADDI_WB   = 4'd12
`endif
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B = 2'b00, SRCB_4 = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;
  function automatic logic is_wait(state_t s);
    return s == S_FETCH || s == S_MEM_READ || s == S_MEM_WRITE;
  endfunction
endpackage

// File: rtl/multicycle_control_decode.sv
// multicycle_control_decode: Moore control word per state; only FETCH looks at mem_ready.
module multicycle_control_decode
  import multicycle_control_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        ctrl.alu_src_b = SRCB_4;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
`ifdef MC_ADDI_EN
      S_MEM_ADDR, S_ADDI_EX: begin
`else
      S_MEM_ADDR: begin
`endif
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
`ifdef MC_ADDI_EN
      S_ADDI_WB: ctrl.reg_write = 1'b1;
`endif
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control FSM with mem_ready watchdog.
// Define MC_ADDI_EN to add the addi instruction (ADDI_EX/ADDI_WB states).
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int WAIT_W       = 4,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [1:0] AluOp,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state_dbg
);
  state_t state, next;
  ctrl_t ctrl;
  logic [WAIT_W-1:0] cnt;
  logic timeout;
  assign timeout = is_wait(state) && !mem_ready && cnt == WAIT_W'(MEM_WAIT_MAX - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= next;
  always_comb begin
    next = S_FETCH;
    case (state)
      S_IDLE:      next = S_FETCH;
      S_FETCH:     next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        case (opcode)
          OP_RTYPE:     next = S_EXECUTE;
          OP_LW, OP_SW: next = S_MEM_ADDR;
          OP_BEQ:       next = S_BRANCH;
          OP_J:         next = S_JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      next = S_ADDI_EX;
`endif
          default:      next = S_FETCH;
        endcase
      S_MEM_ADDR:  next = opcode == OP_SW ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  next = mem_ready ? S_MEM_WB : timeout ? S_FETCH : S_MEM_READ;
      S_MEM_WRITE: next = (mem_ready || timeout) ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   next = S_R_WB;
`ifdef MC_ADDI_EN
      S_ADDI_EX:   next = S_ADDI_WB;
`endif
      default:     next = S_FETCH;
    endcase
  end
  // Timeout in FETCH keeps the state, so it must clear the counter explicitly.
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (next != state || mem_ready || timeout) ? '0 : cnt + 1'b1;
  multicycle_control_decode u_decode (
    .state    (state),
    .mem_ready(mem_ready),
    .ctrl     (ctrl)
  );
  assign {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
          RegWrite, AluSrcA, AluSrcB, AluOp, PCSource} = ctrl;
  assign illegal_op  = state == S_DECODE && next == S_FETCH;
  assign mem_timeout = timeout;
  assign state_dbg   = state;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed scenarios plus randomized traffic checked against an instruction-level model.
module tb_multicycle_control;
  import multicycle_control_pkg::*;
  localparam int MAXW = 15;
  logic clk = 1'b0, reset = 1'b1, mem_ready = 1'b1;
  logic [5:0] opcode = OP_LW;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, AluSrcA;
  logic [1:0] AluSrcB, AluOp, PCSource;
  logic illegal_op, mem_timeout;
  logic [3:0] state_dbg;
  logic [15:0] dut_ctrl;
  int n_cmp = 0, n_bad = 0, stall = 0;
  state_t m_st;
  int m_wait;

  always #5 clk = ~clk;

  multicycle_control #(.WAIT_W(4), .MEM_WAIT_MAX(MAXW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOp(AluOp),
    .PCSource(PCSource), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
    .state_dbg(state_dbg)
  );

  assign dut_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                     RegWrite, AluSrcA, AluSrcB, AluOp, PCSource};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Control word {pcw,pcwc,iord,mr,mw,irw,m2r,rdst,rw,asa,asb,aop,psrc} taken from the state table.
  function automatic logic [15:0] exp_ctrl(state_t s, logic mr);
    case (s)
      S_FETCH:     return {mr, 2'b00, 1'b1, 1'b0, mr, 4'b0000, 6'b01_00_00};
      S_DECODE:    return {10'b0, 6'b11_00_00};
      S_MEM_ADDR:  return {9'b0, 1'b1, 6'b10_00_00};
      S_MEM_READ:  return {2'b00, 2'b11, 6'b0, 6'b0};
      S_MEM_WB:    return {6'b0, 4'b1010, 6'b0};
      S_MEM_WRITE: return {2'b00, 3'b101, 5'b0, 6'b0};
      S_EXECUTE:   return {9'b0, 1'b1, 6'b00_10_00};
      S_R_WB:      return {7'b0, 3'b110, 6'b0};
      S_BRANCH:    return {2'b01, 7'b0, 1'b1, 6'b00_01_01};
      S_JUMP:      return {1'b1, 9'b0, 6'b00_00_10};
`ifdef MC_ADDI_EN
      S_ADDI_EX:   return {9'b0, 1'b1, 6'b10_00_00};
      S_ADDI_WB:   return {8'b0, 2'b10, 6'b0};
`endif
      default:     return 16'h0;
    endcase
  endfunction

  function automatic state_t after_decode(logic [5:0] op);
    if (op == OP_RTYPE) return S_EXECUTE;
    if (op == OP_LW || op == OP_SW) return S_MEM_ADDR;
    if (op == OP_BEQ) return S_BRANCH;
    if (op == OP_J) return S_JUMP;
`ifdef MC_ADDI_EN
    if (op == OP_ADDI) return S_ADDI_EX;
`endif
    return S_FETCH;
  endfunction

  function automatic bit legal(logic [5:0] op);
    return after_decode(op) != S_FETCH;
  endfunction

  function automatic bit waiting(state_t s);
    return s == S_FETCH || s == S_MEM_READ || s == S_MEM_WRITE;
  endfunction

  // Abort happens on the MAXW-th consecutive not-ready cycle of one wait.
  function automatic bit tmo_now();
    return waiting(m_st) && !mem_ready && (m_wait + 1 == MAXW);
  endfunction

  always @(posedge clk or posedge reset)
    if (reset) begin
      m_st   <= S_IDLE;
      m_wait <= 0;
    end else begin
      m_wait <= (waiting(m_st) && !mem_ready && !tmo_now()) ? m_wait + 1 : 0;
      if (m_st == S_IDLE) m_st <= S_FETCH;
      else if (m_st == S_DECODE) m_st <= after_decode(opcode);
      else if (m_st == S_MEM_ADDR) m_st <= (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      else if (m_st == S_EXECUTE) m_st <= S_R_WB;
`ifdef MC_ADDI_EN
      else if (m_st == S_ADDI_EX) m_st <= S_ADDI_WB;
`endif
      else if (waiting(m_st)) begin
        if (mem_ready) m_st <= (m_st == S_FETCH) ? S_DECODE : (m_st == S_MEM_READ) ? S_MEM_WB : S_FETCH;
        else if (tmo_now()) m_st <= S_FETCH;
      end else m_st <= S_FETCH;
    end

  always @(negedge clk) begin
    chk("state", state_dbg, m_st);
    chk("ctrl", dut_ctrl, exp_ctrl(m_st, mem_ready));
    chk("illegal_op", illegal_op, m_st == S_DECODE && !legal(opcode));
    chk("mem_timeout", mem_timeout, tmo_now());
  end

  task automatic go(input logic mr, input logic [5:0] op, input state_t s);
    @(posedge clk);
    #1 mem_ready = mr;
    opcode = op;
    @(negedge clk);
    chk("seq", state_dbg, s);
  endtask

  function automatic logic [5:0] pick();
    case ($urandom_range(0, 6))
      0: return OP_RTYPE;
      1: return OP_LW;
      2: return OP_SW;
      3: return OP_BEQ;
      4: return OP_J;
      5: return OP_ADDI;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    repeat (3) begin
      @(negedge clk);
      chk("rst_state", state_dbg, S_IDLE);
      chk("rst_ctrl", dut_ctrl, 16'h0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_state", state_dbg, S_IDLE);
    chk("idle_ctrl", dut_ctrl, 16'h0);
    go(1'b1, OP_LW, S_FETCH);
    chk("fetch_mr", MemRead, 1'b1);
    chk("fetch_irw", IRWrite, 1'b1);
    chk("fetch_pcw", PCWrite, 1'b1);
    chk("fetch_asb", AluSrcB, 2'b01);
    go(1'b1, OP_LW, S_DECODE);
    go(1'b1, OP_LW, S_MEM_ADDR);
    go(1'b1, OP_LW, S_MEM_READ);
    go(1'b1, OP_LW, S_MEM_WB);
    chk("lw_wb", {RegWrite, MemtoReg, RegDst}, 3'b110);
    go(1'b1, OP_RTYPE, S_FETCH);
    go(1'b1, OP_RTYPE, S_DECODE);
    go(1'b1, OP_RTYPE, S_EXECUTE);
    go(1'b1, OP_RTYPE, S_R_WB);
    chk("r_wb", {RegDst, MemtoReg}, 2'b10);
    go(1'b1, OP_BEQ, S_FETCH);
    go(1'b1, OP_BEQ, S_DECODE);
    go(1'b1, OP_BEQ, S_BRANCH);
    chk("beq", {PCWriteCond, AluOp, PCSource}, 5'b1_01_01);
    go(1'b1, OP_J, S_FETCH);
    go(1'b1, OP_J, S_DECODE);
    go(1'b1, OP_J, S_JUMP);
    chk("jump", {PCWrite, PCSource}, 3'b1_10);
    go(1'b1, OP_SW, S_FETCH);
    go(1'b1, OP_SW, S_DECODE);
    go(1'b1, OP_SW, S_MEM_ADDR);
    for (int i = 0; i < 6; i++) begin
      go(i == 5, OP_SW, S_MEM_WRITE);
      chk("sw_memwrite", MemWrite, 1'b1);
      chk("sw_no_tmo", mem_timeout, 1'b0);
    end
    for (int r = 0; r < 2; r++)
      for (int i = 1; i <= 15; i++) begin
        go(1'b0, OP_RTYPE, S_FETCH);
        chk("tmo_15th", mem_timeout, i == 15);
        chk("tmo_irw", IRWrite, 1'b0);
      end
    go(1'b1, OP_ADDI, S_FETCH);
    go(1'b1, OP_ADDI, S_DECODE);
`ifdef MC_ADDI_EN
    chk("addi_legal", illegal_op, 1'b0);
    go(1'b1, OP_ADDI, S_ADDI_EX);
    go(1'b1, OP_ADDI, S_ADDI_WB);
    chk("addi_wb", RegWrite, 1'b1);
`else
    chk("addi_illegal", illegal_op, 1'b1);
`endif
    go(1'b1, OP_LW, S_FETCH);
    go(1'b1, OP_LW, S_DECODE);
    go(1'b1, OP_LW, S_MEM_ADDR);
    go(1'b0, OP_LW, S_MEM_READ);
    #1 reset = 1'b1;
    #1 chk("async_rst_state", state_dbg, S_IDLE);
    chk("async_rst_ctrl", dut_ctrl, 16'h0);
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      if (reset) reset = 1'b0;
      if (m_st == S_FETCH || m_st == S_IDLE) opcode = pick();
      if (stall > 0) begin
        mem_ready = 1'b0;
        stall--;
      end else if ($urandom_range(0, 40) == 0) begin
        stall = $urandom_range(8, 20);
        mem_ready = 1'b0;
      end else mem_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 250) == 0) #2 reset = 1'b1;
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
